// File: rtl/dsp_mac_multich.sv
// Multi-channel MAC: per enabled channel, a LEN-tap dot product of SAMPLE[ch] against a shared
// coefficient memory, shifted and saturated onto dout with a one-cycle valid strobe.
module dsp_mac_multich #(
  parameter logic RST_VAL   = 1'b0,
  parameter int   BUS_WIDTH = 24,
  parameter int   CHANNELS  = 4,
  parameter int   MEM_AW    = 6,
  parameter int   COEF_W    = 14
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 start,
  input  logic [7:0]           param,
  input  logic [2:0]           addr,
  input  logic [BUS_WIDTH-1:0] din,
  input  logic                 we,
  output logic [BUS_WIDTH-1:0] dout,
  output logic                 dout_valid,
  output logic [1:0]           dout_ch,
  output logic                 busy,
  output logic                 done,
  output logic [MEM_AW-1:0]    memaddr,
  input  logic [COEF_W-1:0]    memdout
);
  localparam int PW = COEF_W + BUS_WIDTH;
  localparam int AW = PW + MEM_AW;
  localparam logic signed [AW-1:0] SMAX = {{(AW-BUS_WIDTH+1){1'b0}}, {(BUS_WIDTH-1){1'b1}}};
  localparam logic signed [AW-1:0] SMIN = ~SMAX;

  typedef enum logic [2:0] {IDLE, RUN, DRAIN, EMIT, FIN} state_t;

  state_t                              state_q;
  logic [MEM_AW-1:0]                   base_q, len_q, tap_q, memaddr_q;
  logic [CHANNELS-1:0]                 mask_q, rem_q;
  logic [CHANNELS-1:0][BUS_WIDTH-1:0]  smp_q;
  logic [4:0]                          shift_q;
  logic [1:0]                          ch_q, dout_ch_q;
  logic signed [AW-1:0]                acc_q;
  logic [BUS_WIDTH-1:0]                dout_q;
  logic                                dout_vld_q, busy_q, done_q;

  logic                    wr_ok;
  logic [MEM_AW-1:0]       base_f, len_m1;
  logic [CHANNELS-1:0]     mask_f, rem_d;
  logic [1:0]              ch_d;
  logic signed [COEF_W-1:0]    coef;
  logic signed [BUS_WIDTH-1:0] smp_cur;
  logic signed [PW-1:0]    prod;
  logic signed [AW-1:0]    acc_d, shifted;
  logic [BUS_WIDTH-1:0]    sat_val;
  logic                    unused_param;

  assign unused_param = ^param[7:5];
  assign wr_ok  = we & (state_q == IDLE);
  // A write in the start cycle must be seen by that run, so forward BASE and MASK.
  assign base_f = (wr_ok && addr == 3'd0) ? din[MEM_AW-1:0]   : base_q;
  assign mask_f = (wr_ok && addr == 3'd2) ? din[CHANNELS-1:0] : mask_q;
  assign len_m1 = len_q - 1'b1;
  assign rem_d  = (state_q == IDLE) ? mask_f : (rem_q & ~(CHANNELS'(1) << ch_q));

  always_comb begin
    ch_d = '0;
    for (int n = CHANNELS-1; n >= 0; n--)
      if (rem_d[n]) ch_d = 2'(n);
  end

  assign coef    = $signed(memdout);
  assign smp_cur = $signed(smp_q[ch_q]);
  assign prod    = PW'(coef) * PW'(smp_cur);
  assign acc_d   = acc_q + AW'(prod);
  assign shifted = acc_q >>> shift_q;
  assign sat_val = (shifted > SMAX) ? SMAX[BUS_WIDTH-1:0] :
                   (shifted < SMIN) ? SMIN[BUS_WIDTH-1:0] : shifted[BUS_WIDTH-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      base_q     <= '0;
      len_q      <= '0;
      mask_q     <= '0;
      smp_q      <= '0;
      shift_q    <= '0;
      rem_q      <= '0;
      ch_q       <= '0;
      tap_q      <= '0;
      acc_q      <= '0;
      memaddr_q  <= '0;
      dout_q     <= {BUS_WIDTH{RST_VAL}};
      dout_vld_q <= 1'b0;
      dout_ch_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else if (en) begin
      dout_vld_q <= 1'b0;
      done_q     <= 1'b0;
      if (wr_ok) begin
        case (addr)
          3'd0: base_q <= din[MEM_AW-1:0];
          3'd1: len_q  <= din[MEM_AW-1:0];
          3'd2: mask_q <= din[CHANNELS-1:0];
          default:
            if (addr[2] && {1'b0, addr[1:0]} < 3'(CHANNELS)) smp_q[addr[1:0]] <= din;
        endcase
      end
      case (state_q)
        IDLE: if (start) begin
          shift_q   <= param[4:0];
          busy_q    <= 1'b1;
          rem_q     <= rem_d;
          ch_q      <= ch_d;
          acc_q     <= '0;
          tap_q     <= '0;
          memaddr_q <= base_f;
          if (rem_d == '0) begin
            done_q  <= 1'b1;
            state_q <= FIN;
          end else begin
            state_q <= RUN;
          end
        end
        RUN: begin
          // Tap 0's data only arrives next cycle; memdout is stale on the first RUN cycle.
          if (tap_q != '0) acc_q <= acc_d;
          if (tap_q == len_m1) begin
            state_q <= DRAIN;
          end else begin
            tap_q     <= tap_q + 1'b1;
            memaddr_q <= memaddr_q + 1'b1;
          end
        end
        DRAIN: begin
          acc_q   <= acc_d;
          state_q <= EMIT;
        end
        EMIT: begin
          dout_q     <= sat_val;
          dout_vld_q <= 1'b1;
          dout_ch_q  <= ch_q;
          acc_q      <= '0;
          rem_q      <= rem_d;
          if (rem_d != '0) begin
            ch_q      <= ch_d;
            tap_q     <= '0;
            memaddr_q <= base_q;
            state_q   <= RUN;
          end else begin
            done_q  <= 1'b1;
            state_q <= FIN;
          end
        end
        FIN: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_vld_q;
  assign dout_ch    = dout_ch_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign memaddr    = memaddr_q;
endmodule

// File: tb/tb_dsp_mac_multich.sv
// Directed bench for dsp_mac_multich: expected results are queued at start and checked as they emerge.
module tb_dsp_mac_multich;
  localparam int BW = 24, CH = 4, MAW = 6, CW = 14;

  logic          clk = 1'b0, rst = 1'b1, en = 1'b1, start = 1'b0, we = 1'b0;
  logic [7:0]    param = '0;
  logic [2:0]    addr = '0;
  logic [BW-1:0] din = '0;
  logic [BW-1:0] dout;
  logic          dout_valid, busy, done;
  logic [1:0]    dout_ch;
  logic [MAW-1:0] memaddr;
  logic [CW-1:0]  memdout;

  dsp_mac_multich #(.RST_VAL(1'b0), .BUS_WIDTH(BW), .CHANNELS(CH), .MEM_AW(MAW), .COEF_W(CW)) dut (
    .clk(clk), .rst(rst), .en(en), .start(start), .param(param), .addr(addr), .din(din), .we(we),
    .dout(dout), .dout_valid(dout_valid), .dout_ch(dout_ch), .busy(busy), .done(done),
    .memaddr(memaddr), .memdout(memdout));

  always #5 clk = ~clk;

  logic signed [CW-1:0] mem [64];
  always @(posedge clk) if (en) memdout <= mem[memaddr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic signed [BW-1:0] smp [CH];
  int base_s = 0, len_s = 0, mask_s = 0;

  typedef struct { logic [BW-1:0] d; logic [1:0] ch; int at; } exp_t;
  exp_t sb[$];
  int n_chk = 0, n_fail = 0, done_cnt = 0, done_at = -1, last_at = 0, exp_done = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    if (done) begin done_cnt++; done_at = cyc; end
    if (dout_valid) begin
      chk("valid_expected", 64'(sb.size() > 0), 64'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("dout", 64'(dout), 64'(e.d));
        chk("dout_ch", 64'(dout_ch), 64'(e.ch));
        chk("valid_cycle", 64'(cyc), 64'(e.at));
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  function automatic logic [BW-1:0] model(input int b, input int l, input int c, input int sh);
    longint acc = 0;
    for (int k = 0; k < l; k++) acc += longint'(mem[(b + k) % 64]) * longint'(smp[c]);
    acc = acc >>> sh;
    if (acc > 64'sd8388607)  return 24'h7FFFFF;
    if (acc < -64'sd8388608) return 24'h800000;
    return acc[BW-1:0];
  endfunction

  task automatic shadow(input int a, input int d);
    case (a)
      0: base_s = d % 64;
      1: len_s  = d % 64;
      2: mask_s = d % 16;
      default: if (a >= 4) smp[a-4] = BW'(d);
    endcase
  endtask

  task automatic wr(input int a, input int d);
    addr = 3'(a); din = BW'(d); we = 1'b1; shadow(a, d);
    tick(); we = 1'b0;
  endtask

  // Write without shadow update: used only while busy, where the DUT must ignore it.
  task automatic poke(input int a, input int d);
    addr = 3'(a); din = BW'(d); we = 1'b1;
    tick(); we = 1'b0;
  endtask

  // Start a run; optionally a register write in the same cycle, and a known en=0 stall length.
  task automatic go(input int sh, input int stall, input bit wr_same, input int wa, input int wd);
    int leff, t;
    if (wr_same) begin addr = 3'(wa); din = BW'(wd); we = 1'b1; shadow(wa, wd); end
    leff = (len_s == 0) ? 64 : len_s;
    param = 8'(sh); start = 1'b1;
    t = cyc + leff + 3 + stall;
    for (int c = 0; c < CH; c++) if (mask_s[c]) begin
      sb.push_back('{d: model(base_s, leff, c, sh), ch: 2'(c), at: t});
      last_at = t;
      t += leff + 2;
    end
    if (mask_s == 0) last_at = cyc + 1;
    exp_done = done_cnt + 1;
    tick();
    start = 1'b0; we = 1'b0;
  endtask

  task automatic finish_run(input string name);
    for (int i = 0; i < 400 && (busy || sb.size() != 0); i++) tick();
    chk({name, "_busy_end"}, 64'(busy), 64'd0);
    chk({name, "_sb_empty"}, 64'(sb.size()), 64'd0);
    chk({name, "_done_cnt"}, 64'(done_cnt), 64'(exp_done));
    chk({name, "_done_cycle"}, 64'(done_at), 64'(last_at));
  endtask

  initial begin
    int dc;
    for (int i = 0; i < 64; i++) mem[i] = '0;
    for (int i = 0; i < CH; i++) smp[i] = '0;
    tick(); tick();
    chk("rst_dout", 64'(dout), 64'd0);
    chk("rst_valid", 64'(dout_valid), 64'd0);
    chk("rst_ch", 64'(dout_ch), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_memaddr", 64'(memaddr), 64'd0);
    rst = 1'b0; tick();

    // 1: single channel, 4 taps
    for (int i = 0; i < 4; i++) mem[i] = CW'(i + 1);
    wr(0, 0); wr(1, 4); wr(2, 1); wr(4, 3);
    go(0, 0, 0, 0, 0);
    chk("t1_busy", 64'(busy), 64'd1);
    finish_run("t1");

    // 2: channels 1 and 3, shift 1; mask written in the start cycle
    mem[8] = 14'sd10; mem[9] = 14'sd10;
    wr(0, 8); wr(1, 2); wr(5, -2); wr(7, 5); wr(2, 0);
    go(1, 0, 1, 2, 4'b1010);
    finish_run("t2");

    // 3: address wrap, then LEN=0 means 64 taps
    mem[62] = 14'sd7; mem[63] = -14'sd3; mem[0] = 14'sd2; mem[1] = 14'sd5;
    wr(0, 62); wr(1, 4); wr(2, 1); wr(4, 11);
    go(0, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      chk("t3_memaddr", 64'(memaddr), 64'((62 + k) % 64));
      tick();
    end
    finish_run("t3a");
    for (int i = 0; i < 64; i++) mem[i] = CW'($urandom);
    wr(0, 5); wr(1, 0); wr(4, 1000);
    go(2, 0, 0, 0, 0);
    finish_run("t3b");

    // 4: positive and negative saturation
    mem[0] = 14'sd8191;
    wr(0, 0); wr(1, 1); wr(4, 24'h7FFFFF);
    go(0, 0, 0, 0, 0);
    finish_run("t4p");
    wr(4, 24'h800000);
    go(0, 0, 0, 0, 0);
    finish_run("t4n");

    // 5: reset mid-run, start while busy, en stall
    for (int i = 0; i < 4; i++) mem[i] = CW'(i + 1);
    wr(1, 4); wr(4, 9);
    dc = done_cnt;
    go(0, 0, 0, 0, 0);
    tick(); tick();
    rst = 1'b1; tick();
    sb.delete();
    chk("t5_rst_busy", 64'(busy), 64'd0);
    chk("t5_rst_dout", 64'(dout), 64'd0);
    rst = 1'b0;
    for (int i = 0; i < 12; i++) tick();
    chk("t5_no_done", 64'(done_cnt), 64'(dc));
    chk("t5_idle_busy", 64'(busy), 64'd0);
    for (int i = 0; i < CH; i++) smp[i] = '0;
    base_s = 0; len_s = 0; mask_s = 0;
    wr(0, 0); wr(1, 4); wr(2, 1); wr(4, -7);
    go(0, 0, 0, 0, 0);
    tick(); start = 1'b1; tick(); start = 1'b0;
    finish_run("t5_restart");
    go(0, 3, 0, 0, 0);
    tick(); tick();
    en = 1'b0; tick(); tick(); tick(); en = 1'b1;
    finish_run("t5_stall");

    // 6: writes while busy are ignored; empty mask finishes at once
    wr(4, 3);
    go(0, 0, 0, 0, 0);
    poke(4, 100); poke(1, 1); poke(2, 15);
    finish_run("t6_busywr");
    go(0, 0, 0, 0, 0);
    finish_run("t6_regs_kept");
    wr(2, 0);
    go(0, 0, 0, 0, 0);
    chk("t6_empty_done", 64'(done), 64'd1);
    finish_run("t6_empty");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
